// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy movement controller.
package enemy_pkg;

  localparam int COORD_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CHECK,
    MOVE,
    DEAD
  } state_t;

  typedef enum logic [1:0] {
    FACE_UP    = 2'd0,
    FACE_RIGHT = 2'd1,
    FACE_DOWN  = 2'd2,
    FACE_LEFT  = 2'd3
  } facing_t;

  // Keypad-style direction codes produced by the random stage
  localparam logic [3:0] RND_UP    = 4'd8;
  localparam logic [3:0] RND_RIGHT = 4'd6;
  localparam logic [3:0] RND_DOWN  = 4'd2;
  localparam logic [3:0] RND_LEFT  = 4'd4;
  localparam logic [3:0] RND_STAY  = 4'd5;

  function automatic logic [1:0] cw_next(input logic [1:0] f);
    return f + 2'd1;
  endfunction

  function automatic logic [3:0] face_to_rnd(input logic [1:0] f);
    case (f)
      FACE_UP:    return RND_UP;
      FACE_RIGHT: return RND_RIGHT;
      FACE_DOWN:  return RND_DOWN;
      FACE_LEFT:  return RND_LEFT;
      default:    return RND_STAY;
    endcase
  endfunction

endpackage

// File: rtl/dir_decode.sv
// Combinational decode of a random direction code into facing and a unit step.
module dir_decode
  import enemy_pkg::*;
(
  input  logic        [3:0] rnd,
  output logic              valid,
  output logic        [1:0] face,
  output logic signed [1:0] dx,
  output logic signed [1:0] dy
);

  // Row 0 is the top of the grid, so "up" is a negative y step
  always_comb begin
    valid = 1'b0;
    face  = FACE_DOWN;
    dx    = 2'sd0;
    dy    = 2'sd0;
    case (rnd)
      RND_UP: begin
        valid = 1'b1;
        face  = FACE_UP;
        dy    = -2'sd1;
      end
      RND_RIGHT: begin
        valid = 1'b1;
        face  = FACE_RIGHT;
        dx    = 2'sd1;
      end
      RND_DOWN: begin
        valid = 1'b1;
        face  = FACE_DOWN;
        dy    = 2'sd1;
      end
      RND_LEFT: begin
        valid = 1'b1;
        face  = FACE_LEFT;
        dx    = -2'sd1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/enemy_move_ctrl.sv
// Enemy movement FSM: periodic random step, map check handshake, kill handling.
// Define ENEMY_RETRY_EN to retry a failed attempt once in the clockwise-next direction.
module enemy_move_ctrl
  import enemy_pkg::*;
#(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 12,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int MOVE_PERIOD = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic [3:0]         rnd,
  input  logic               kill,
  output logic               chk_valid,
  output logic [COORD_W-1:0] chk_x,
  output logic [COORD_W-1:0] chk_y,
  input  logic               chk_ready,
  input  logic               chk_blocked,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         facing,
  output logic               dead
);

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_H - 1);
  localparam logic [7:0]         CNT_TOP = 8'(MOVE_PERIOD - 1);

  state_t             state;
  logic [7:0]         tick_cnt;
  logic [3:0]         dec_rnd;
  logic               dec_valid;
  logic [1:0]         dec_face;
  logic signed [1:0]  dx;
  logic signed [1:0]  dy;
  logic               off_grid;
  logic [COORD_W-1:0] tgt_x;
  logic [COORD_W-1:0] tgt_y;

`ifdef ENEMY_RETRY_EN
  logic retry_pend;
  // A retry re-enters SAMPLE and decodes the direction after the one just tried
  assign dec_rnd = retry_pend ? face_to_rnd(cw_next(facing)) : rnd;
`else
  assign dec_rnd = rnd;
`endif

  dir_decode u_dir_decode (
    .rnd   (dec_rnd),
    .valid (dec_valid),
    .face  (dec_face),
    .dx    (dx),
    .dy    (dy)
  );

  assign off_grid = (dx == -2'sd1 && pos_x == '0)    ||
                    (dx ==  2'sd1 && pos_x == X_MAX) ||
                    (dy == -2'sd1 && pos_y == '0)    ||
                    (dy ==  2'sd1 && pos_y == Y_MAX);
  assign tgt_x = pos_x + {{(COORD_W-2){dx[1]}}, dx};
  assign tgt_y = pos_y + {{(COORD_W-2){dy[1]}}, dy};

  // kill outranks every other transition, including a same-cycle handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      pos_x     <= COORD_W'(START_X);
      pos_y     <= COORD_W'(START_Y);
      facing    <= FACE_DOWN;
      chk_valid <= 1'b0;
      chk_x     <= '0;
      chk_y     <= '0;
      dead      <= 1'b0;
`ifdef ENEMY_RETRY_EN
      retry_pend <= 1'b0;
`endif
    end else if (kill) begin
      state     <= DEAD;
      dead      <= 1'b1;
      chk_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            if (tick_cnt == CNT_TOP) begin
              tick_cnt <= '0;
              state    <= SAMPLE;
            end else begin
              tick_cnt <= tick_cnt + 8'd1;
            end
          end
        end
        SAMPLE: begin
          if (!dec_valid) begin
            state <= IDLE;
          end else begin
            facing <= dec_face;
            if (off_grid) begin
`ifdef ENEMY_RETRY_EN
              if (!retry_pend) begin
                retry_pend <= 1'b1;
                state      <= SAMPLE;
              end else begin
                retry_pend <= 1'b0;
                state      <= IDLE;
              end
`else
              state <= IDLE;
`endif
            end else begin
              chk_x     <= tgt_x;
              chk_y     <= tgt_y;
              chk_valid <= 1'b1;
              state     <= CHECK;
            end
          end
        end
        CHECK: begin
          if (chk_ready) begin
            chk_valid <= 1'b0;
            if (chk_blocked) begin
`ifdef ENEMY_RETRY_EN
              if (!retry_pend) begin
                retry_pend <= 1'b1;
                state      <= SAMPLE;
              end else begin
                retry_pend <= 1'b0;
                state      <= IDLE;
              end
`else
              state <= IDLE;
`endif
            end else begin
              state <= MOVE;
            end
          end
        end
        MOVE: begin
          pos_x <= chk_x;
          pos_y <= chk_y;
          state <= IDLE;
`ifdef ENEMY_RETRY_EN
          retry_pend <= 1'b0;
`endif
        end
        DEAD: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_move_ctrl.sv
// Directed self-checking bench for enemy_move_ctrl in its default configuration.
module tb_enemy_move_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] rnd;
  logic       kill;
  logic       chk_valid;
  logic [3:0] chk_x;
  logic [3:0] chk_y;
  logic       chk_ready;
  logic       chk_blocked;
  logic [3:0] pos_x;
  logic [3:0] pos_y;
  logic [1:0] facing;
  logic       dead;

  int vecCount = 0;
  int errCount = 0;

  always #5 clock = ~clock;

  enemy_move_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .rnd         (rnd),
    .kill        (kill),
    .chk_valid   (chk_valid),
    .chk_x       (chk_x),
    .chk_y       (chk_y),
    .chk_ready   (chk_ready),
    .chk_blocked (chk_blocked),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .facing      (facing),
    .dead        (dead)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Each tick is a one-cycle pulse followed by one idle cycle; returns just after
  // the edge that sampled the last tick
  task automatic applyStimulus(input int nTicks, input logic [3:0] code);
    rnd = code;
    for (int i = 0; i < nTicks; i++) begin
      @(negedge clock);
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
    end
  endtask

  task automatic runMove(input logic [3:0] code);
    applyStimulus(8, code);
    repeat (3) @(negedge clock);
  endtask

  task automatic watchNoRequest(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clock);
      seen = seen | chk_valid;
    end
    checkOutput(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    tick        = 1'b0;
    kill        = 1'b0;
    rnd         = 4'd5;
    chk_ready   = 1'b1;
    chk_blocked = 1'b0;

    @(negedge clock);
    checkOutput("rst pos_x", 32'(pos_x), 32'd1);
    checkOutput("rst pos_y", 32'(pos_y), 32'd1);
    checkOutput("rst facing", 32'(facing), 32'd2);
    checkOutput("rst chk_valid", 32'(chk_valid), 32'd0);
    checkOutput("rst chk_xy", 32'({chk_x, chk_y}), 32'h00);
    checkOutput("rst dead", 32'(dead), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Seven ticks are not enough; the eighth launches a move to the right
    applyStimulus(7, 4'd6);
    repeat (3) @(negedge clock);
    checkOutput("7 ticks no req", 32'(chk_valid), 32'd0);
    checkOutput("7 ticks facing", 32'(facing), 32'd2);
    applyStimulus(1, 4'd6);
    @(negedge clock);
    checkOutput("right chk_valid", 32'(chk_valid), 32'd1);
    checkOutput("right chk_xy", 32'({chk_x, chk_y}), 32'h21);
    checkOutput("right facing", 32'(facing), 32'd1);
    @(negedge clock);
    checkOutput("right valid drop", 32'(chk_valid), 32'd0);
    checkOutput("right pos early", 32'(pos_x), 32'd1);
    @(negedge clock);
    checkOutput("right pos", 32'({pos_x, pos_y}), 32'h21);

    // Walk to the left edge at (0,5)
    runMove(4'd4);
    runMove(4'd4);
    checkOutput("left edge pos", 32'({pos_x, pos_y}), 32'h01);
    checkOutput("left facing", 32'(facing), 32'd3);
    for (int i = 0; i < 4; i++) runMove(4'd2);
    checkOutput("corner pos", 32'({pos_x, pos_y}), 32'h05);
    checkOutput("down facing", 32'(facing), 32'd2);

    // Leaving the grid on the left: turn only, no request
    applyStimulus(8, 4'd4);
    watchNoRequest("offgrid no req", 4);
    checkOutput("offgrid pos", 32'({pos_x, pos_y}), 32'h05);
    checkOutput("offgrid facing", 32'(facing), 32'd3);

    // Stay and undefined codes leave facing alone
    applyStimulus(8, 4'd5);
    watchNoRequest("stay no req", 4);
    checkOutput("stay facing", 32'(facing), 32'd3);
    applyStimulus(8, 4'd0);
    watchNoRequest("code0 no req", 4);
    checkOutput("code0 facing", 32'(facing), 32'd3);

    // Stalled request, ticks during CHECK, then a blocked answer
    chk_ready = 1'b0;
    applyStimulus(8, 4'd6);
    @(negedge clock);
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall hold %0d", i), 32'({chk_valid, chk_x, chk_y}), 32'h115);
      @(negedge clock);
    end
    tick        = 1'b0;
    chk_ready   = 1'b1;
    chk_blocked = 1'b1;
    @(negedge clock);
    chk_blocked = 1'b0;
    checkOutput("blocked drop", 32'(chk_valid), 32'd0);
    repeat (2) @(negedge clock);
    checkOutput("blocked pos", 32'({pos_x, pos_y}), 32'h05);
    checkOutput("blocked facing", 32'(facing), 32'd1);
    checkOutput("blocked no retry", 32'(chk_valid), 32'd0);

    // Ticks seen in CHECK were not counted: seven fresh ticks still do nothing
    applyStimulus(7, 4'd6);
    repeat (3) @(negedge clock);
    checkOutput("ignored ticks pos", 32'(pos_x), 32'd0);
    checkOutput("ignored ticks req", 32'(chk_valid), 32'd0);

    // Kill during the handshake cycle wins over the move
    applyStimulus(1, 4'd6);
    @(negedge clock);
    checkOutput("kill pre valid", 32'(chk_valid), 32'd1);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    checkOutput("kill dead", 32'(dead), 32'd1);
    checkOutput("kill valid", 32'(chk_valid), 32'd0);
    repeat (2) @(negedge clock);
    checkOutput("kill pos", 32'({pos_x, pos_y}), 32'h05);
    applyStimulus(8, 4'd8);
    watchNoRequest("dead no req", 4);
    checkOutput("dead pos", 32'({pos_x, pos_y}), 32'h05);
    checkOutput("dead facing", 32'(facing), 32'd1);
    checkOutput("dead sticky", 32'(dead), 32'd1);

    // Reset revives; then reset again while a request is pending
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("revive dead", 32'(dead), 32'd0);
    checkOutput("revive pos", 32'({pos_x, pos_y}), 32'h11);
    @(negedge clock);
    reset = 1'b0;
    runMove(4'd6);
    checkOutput("revive move", 32'({pos_x, pos_y}), 32'h21);
    chk_ready = 1'b0;
    applyStimulus(8, 4'd6);
    @(negedge clock);
    checkOutput("pend valid", 32'({chk_valid, chk_x, chk_y}), 32'h131);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async rst valid", 32'(chk_valid), 32'd0);
    checkOutput("async rst pos", 32'({pos_x, pos_y}), 32'h11);
    checkOutput("async rst facing", 32'(facing), 32'd2);
    @(negedge clock);
    reset     = 1'b0;
    chk_ready = 1'b1;
    watchNoRequest("abandoned req", 3);
    checkOutput("abandoned pos", 32'({pos_x, pos_y}), 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
